qpu_dtcm_ctrl: RTL and testbench
================================

# qpu_dtcm_ctrl

Data-TCM controller directly downstream of the QPU load/store unit. Accepts ICB commands from the LSU's DTCM port, drives a single-port synchronous SRAM, and returns responses on the ICB response channel. It sustains one access per cycle under a ready-driven response channel and buffers responses in a small credit-checked FIFO. Misaligned accesses are flagged without touching the SRAM.

## Interface
Parameters:
- XLEN, 32, data width (multiple of 8)
- AW, 16, byte-address width (matches QPU_DTCM_ADDR_WIDTH)
- RSP_DEPTH, 2, response FIFO entries (≥2)

Ports:
- clk  in  1  single clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- dtcm_icb_cmd_valid  in  1  command valid
- dtcm_icb_cmd_ready  out  1  command ready
- dtcm_icb_cmd_addr  in  AW  byte address
- dtcm_icb_cmd_read  in  1  1 = read, 0 = write
- dtcm_icb_cmd_wdata  in  XLEN  write data
- dtcm_icb_cmd_wmask  in  XLEN/8  byte write enables
- dtcm_icb_rsp_valid  out  1  response valid
- dtcm_icb_rsp_ready  in  1  response ready
- dtcm_icb_rsp_rdata  out  XLEN  read data (0 for writes and errors)
- dtcm_icb_rsp_err  out  1  misaligned access
- ram_cs  out  1  SRAM chip select
- ram_we  out  1  SRAM write enable
- ram_addr  out  AW-2  SRAM word address
- ram_wem  out  XLEN/8  SRAM byte enables
- ram_din  out  XLEN  SRAM write data
- ram_dout  in  XLEN  SRAM read data; valid the cycle after a read cs
- dtcm_active  out  1  busy indicator (clock-gating hint)

## Operation
- Accept: `acc = cmd_valid & cmd_ready`. `mis = (addr[1:0] != 0)`.
- SRAM drive: `ram_cs = acc & ~mis`, `ram_we = ~cmd_read`, `ram_addr = addr[AW-1:2]`, `ram_wem = wmask`, `ram_din = wdata`. These outputs are combinational from the command and are don't-care when cs = 0.
- Stage s1: a register set {s1_v, s1_rd, s1_err}, loaded every cycle with {acc, read & ~mis, mis}.
- Push: when s1_v = 1, one entry is written into the FIFO with rdata = s1_rd ? ram_dout : 0 and err = s1_err.
- FIFO: RSP_DEPTH entries, count `cnt`.
  - rsp_valid = (cnt != 0); the head drives rdata and err.
  - Pop = rsp_valid & rsp_ready.
  - Push and pop in the same cycle are allowed; cnt is unchanged.
- Credit: `cmd_ready = ~rst & ((cnt + s1_v - pop) < RSP_DEPTH)`. This guarantees no FIFO overflow.
- `dtcm_active = cmd_valid | s1_v | (cnt != 0)`.
- Writes to an address are visible to any read accepted at least one cycle later (SRAM ordering). Responses return strictly in command order.

## Timing
- Reset (asynchronous, immediate): s1_v = 0, cnt = 0, pointers = 0.
  - Outputs during reset: cmd_ready = 0, rsp_valid = 0, ram_cs = 0, rsp_rdata = 0, rsp_err = 0, dtcm_active = cmd_valid.
- Latency: command accepted in cycle N gives rsp_valid high in cycle N+2 (with an empty FIFO and rsp_ready = 1).
- Throughput: one command per cycle indefinitely while rsp_ready = 1. With RSP_DEPTH = 2 the steady state is s1_v = 1, cnt = 1, pop = 1, so ready stays high.
- Backpressure: with rsp_ready held low, at most RSP_DEPTH commands are accepted before cmd_ready drops. cmd_ready rises combinationally in the cycle rsp_ready returns.
- Full + simultaneous pop: the credit includes pop, so a new command is accepted in the same cycle.
- Response hold: rsp_valid, once high, stays high with stable rdata and err until popped.
- Pointer wrap: pointers wrap modulo RSP_DEPTH; RSP_DEPTH need not be a power of two.
- Reset mid-operation: in-flight and buffered responses are discarded; no SRAM access occurs while rst is high.

## Structure
- The shared QPU defines file supplies XLEN, the DTCM address width and the ICB field widths. The FIFO depth is local.
- Sub-module: `qpu_rsp_fifo` (parameterised width and depth; provides push/pop/cnt; no fall-through). The controller holds s1, the credit logic and the SRAM mapping.

## Test plan
- Write 0xDEADBEEF, wmask 4'hF, to 0x0010, then read 0x0010 → ram_addr = 4; read response in cycle N+2 returns rdata 0xDEADBEEF, err 0.
- Byte write wmask 4'b0010, data 0x0000AB00, over 0x11223344 → readback 0x1122AB44.
- Read 0x0013 → ram_cs stays 0; response err 1, rdata 0.
- 8 back-to-back reads with rsp_ready = 1 → cmd_ready is never low; 8 responses arrive in order on consecutive cycles.
- rsp_ready = 0 for 10 cycles with cmd_valid held → exactly 2 commands accepted. Releasing ready drains them in order, and a new accept occurs the same cycle.
- Assert rst with cnt = 2 and s1_v = 1 → rsp_valid and cmd_ready are 0 immediately. After deassert: cnt = 0, and the next command completes normally.

Source files
------------

// File: rtl/qpu_dtcm_pkg.sv
// qpu_dtcm_pkg: shared QPU widths for the DTCM path and the alignment helper.
package qpu_dtcm_pkg;

    localparam int QPU_XLEN            = 32;
    localparam int QPU_DTCM_ADDR_WIDTH = 16;

    function automatic logic misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

endpackage

// File: rtl/qpu_rsp_fifo.sv
// qpu_rsp_fifo: response FIFO with arbitrary depth; pointers wrap modulo DEPTH.
module qpu_rsp_fifo #(
    parameter  int W     = 33,
    parameter  int DEPTH = 2,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic [W-1:0]  din_i,
    input  logic          pop_i,
    output logic [W-1:0]  dout_o,
    output logic [CW-1:0] cnt_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        wptr_d = push_i ? ((wptr_q == PW'(DEPTH - 1)) ? '0 : wptr_q + 1'b1) : wptr_q;
        rptr_d = pop_i ? ((rptr_q == PW'(DEPTH - 1)) ? '0 : rptr_q + 1'b1) : rptr_q;
        cnt_d  = cnt_q + CW'(push_i) - CW'(pop_i);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Storage needs no reset: entries are only observed once counted.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wptr_q] <= din_i;
    end

    assign dout_o = mem_q[rptr_q];
    assign cnt_o  = cnt_q;

endmodule

// File: rtl/qpu_dtcm_ctrl.sv
// qpu_dtcm_ctrl: ICB-to-SRAM data TCM controller with credit-checked response buffering.
module qpu_dtcm_ctrl
    import qpu_dtcm_pkg::*;
#(
    parameter int XLEN      = QPU_XLEN,
    parameter int AW        = QPU_DTCM_ADDR_WIDTH,
    parameter int RSP_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dtcm_icb_cmd_valid,
    output logic              dtcm_icb_cmd_ready,
    input  logic [AW-1:0]     dtcm_icb_cmd_addr,
    input  logic              dtcm_icb_cmd_read,
    input  logic [XLEN-1:0]   dtcm_icb_cmd_wdata,
    input  logic [XLEN/8-1:0] dtcm_icb_cmd_wmask,
    output logic              dtcm_icb_rsp_valid,
    input  logic              dtcm_icb_rsp_ready,
    output logic [XLEN-1:0]   dtcm_icb_rsp_rdata,
    output logic              dtcm_icb_rsp_err,
    output logic              ram_cs,
    output logic              ram_we,
    output logic [AW-3:0]     ram_addr,
    output logic [XLEN/8-1:0] ram_wem,
    output logic [XLEN-1:0]   ram_din,
    input  logic [XLEN-1:0]   ram_dout,
    output logic              dtcm_active
);

    localparam int CW = $clog2(RSP_DEPTH + 1);

    logic          acc, mis, pop;
    logic [2:0]    s1_q, s1_d;
    logic [CW-1:0] cnt;
    logic [CW:0]   credit;
    logic [XLEN:0] head;

    // Credit counts the in-flight s1 entry and frees the slot being popped this cycle.
    always_comb begin
        mis                = misaligned(dtcm_icb_cmd_addr[1:0]);
        dtcm_icb_rsp_valid = cnt != '0;
        pop                = dtcm_icb_rsp_valid & dtcm_icb_rsp_ready;
        credit             = {1'b0, cnt} + (CW + 1)'(s1_q[2]) - (CW + 1)'(pop);
        dtcm_icb_cmd_ready = ~rst & (credit < (CW + 1)'(RSP_DEPTH));
        acc                = dtcm_icb_cmd_valid & dtcm_icb_cmd_ready;
        s1_d               = {acc, dtcm_icb_cmd_read & ~mis, mis};
        ram_cs             = acc & ~mis;
        ram_we             = ~dtcm_icb_cmd_read;
        ram_addr           = dtcm_icb_cmd_addr[AW-1:2];
        ram_wem            = dtcm_icb_cmd_wmask;
        ram_din            = dtcm_icb_cmd_wdata;
        dtcm_icb_rsp_rdata = dtcm_icb_rsp_valid ? head[XLEN-1:0] : '0;
        dtcm_icb_rsp_err   = dtcm_icb_rsp_valid & head[XLEN];
        dtcm_active        = dtcm_icb_cmd_valid | s1_q[2] | dtcm_icb_rsp_valid;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) s1_q <= '0;
        else     s1_q <= s1_d;
    end

    qpu_rsp_fifo #(.W(XLEN + 1), .DEPTH(RSP_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push_i(s1_q[2]),
        .din_i ({s1_q[0], s1_q[1] ? ram_dout : {XLEN{1'b0}}}),
        .pop_i (pop),
        .dout_o(head),
        .cnt_o (cnt)
    );

endmodule

// File: tb/tb_qpu_dtcm_ctrl.sv
// tb_qpu_dtcm_ctrl: directed vectors against a behavioural SRAM with a known background pattern.
module tb_qpu_dtcm_ctrl;

    logic        clk = 0, rst = 1;
    logic        cmd_valid = 0, cmd_ready, cmd_read = 0;
    logic [15:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_wmask = '0;
    logic        rsp_valid, rsp_ready = 0, rsp_err;
    logic [31:0] rsp_rdata;
    logic        ram_cs, ram_we, active;
    logic [13:0] ram_addr;
    logic [3:0]  ram_wem;
    logic [31:0] ram_din, ram_dout;

    int pass_n = 0, total_n = 0;

    always #5 clk = ~clk;

    qpu_dtcm_ctrl dut (
        .clk(clk), .rst(rst),
        .dtcm_icb_cmd_valid(cmd_valid), .dtcm_icb_cmd_ready(cmd_ready),
        .dtcm_icb_cmd_addr(cmd_addr), .dtcm_icb_cmd_read(cmd_read),
        .dtcm_icb_cmd_wdata(cmd_wdata), .dtcm_icb_cmd_wmask(cmd_wmask),
        .dtcm_icb_rsp_valid(rsp_valid), .dtcm_icb_rsp_ready(rsp_ready),
        .dtcm_icb_rsp_rdata(rsp_rdata), .dtcm_icb_rsp_err(rsp_err),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wem(ram_wem),
        .ram_din(ram_din), .ram_dout(ram_dout), .dtcm_active(active)
    );

    // Stored word is kept XORed with the background so untouched words read back pat(a).
    function automatic logic [31:0] pat(input logic [13:0] a);
        return {16'hC0DE, 2'b00, a};
    endfunction

    bit [31:0] mem [16384];
    logic [31:0] bmask, cur;
    always_comb begin
        bmask = {{8{ram_wem[3]}}, {8{ram_wem[2]}}, {8{ram_wem[1]}}, {8{ram_wem[0]}}};
        cur   = mem[ram_addr] ^ pat(ram_addr);
    end
    always @(posedge clk) begin
        if (ram_cs && ram_we) mem[ram_addr] <= ((cur & ~bmask) | (ram_din & bmask)) ^ pat(ram_addr);
        if (ram_cs && !ram_we) ram_dout <= cur;
    end

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total_n++;
        if (act === exp) pass_n++;
        else $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    endtask

    task automatic step(input logic v, input logic rd, input logic [15:0] a,
                        input logic [31:0] wd, input logic [3:0] wm, input logic rr);
        @(negedge clk);
        cmd_valid = v; cmd_read = rd; cmd_addr = a; cmd_wdata = wd; cmd_wmask = wm; rsp_ready = rr;
        #1;
    endtask

    typedef struct {
        logic        v, rd;
        logic [15:0] a;
        logic [31:0] wd;
        logic [3:0]  wm;
        logic        e_rdy, e_cs, e_we;
        logic [13:0] e_addr;
        logic        e_rv;
        logic [31:0] e_rdata;
        logic        e_err;
    } vec_t;

    vec_t tv [9];
    int   acc_n;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        tv[0] = '{1'b1, 1'b0, 16'h0010, 32'hDEADBEEF, 4'hF, 1'b1, 1'b1, 1'b1, 14'd4, 1'b0, 32'h0, 1'b0};
        tv[1] = '{1'b1, 1'b1, 16'h0010, 32'h0,        4'h0, 1'b1, 1'b1, 1'b0, 14'd4, 1'b0, 32'h0, 1'b0};
        tv[2] = '{1'b1, 1'b0, 16'h0020, 32'h11223344, 4'hF, 1'b1, 1'b1, 1'b1, 14'd8, 1'b1, 32'h0, 1'b0};
        tv[3] = '{1'b1, 1'b0, 16'h0020, 32'h0000AB00, 4'h2, 1'b1, 1'b1, 1'b1, 14'd8, 1'b1, 32'hDEADBEEF, 1'b0};
        tv[4] = '{1'b1, 1'b1, 16'h0020, 32'h0,        4'h0, 1'b1, 1'b1, 1'b0, 14'd8, 1'b1, 32'h0, 1'b0};
        tv[5] = '{1'b1, 1'b1, 16'h0013, 32'h0,        4'h0, 1'b1, 1'b0, 1'b0, 14'd0, 1'b1, 32'h0, 1'b0};
        tv[6] = '{1'b0, 1'b0, 16'h0000, 32'h0,        4'h0, 1'b1, 1'b0, 1'b0, 14'd0, 1'b1, 32'h1122AB44, 1'b0};
        tv[7] = '{1'b0, 1'b0, 16'h0000, 32'h0,        4'h0, 1'b1, 1'b0, 1'b0, 14'd0, 1'b1, 32'h0, 1'b1};
        tv[8] = '{1'b0, 1'b0, 16'h0000, 32'h0,        4'h0, 1'b1, 1'b0, 1'b0, 14'd0, 1'b0, 32'h0, 1'b0};

        // Outputs while held in reset
        cmd_valid = 1; cmd_read = 1; rsp_ready = 1;
        #2;
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_ram_cs", ram_cs, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_active_hi", active, 1);
        cmd_valid = 0;
        #1;
        chk("rst_active_lo", active, 0);
        repeat (2) @(negedge clk);
        rst = 0;

        for (int i = 0; i < 9; i++) begin
            step(tv[i].v, tv[i].rd, tv[i].a, tv[i].wd, tv[i].wm, 1'b1);
            chk($sformatf("tv%0d_cmd_ready", i), cmd_ready, tv[i].e_rdy);
            chk($sformatf("tv%0d_ram_cs", i), ram_cs, tv[i].e_cs);
            if (tv[i].e_cs) begin
                chk($sformatf("tv%0d_ram_addr", i), ram_addr, tv[i].e_addr);
                chk($sformatf("tv%0d_ram_we", i), ram_we, tv[i].e_we);
            end
            chk($sformatf("tv%0d_rsp_valid", i), rsp_valid, tv[i].e_rv);
            chk($sformatf("tv%0d_rsp_rdata", i), rsp_rdata, tv[i].e_rdata);
            chk($sformatf("tv%0d_rsp_err", i), rsp_err, tv[i].e_err);
        end

        // Eight back-to-back reads: responses on consecutive cycles from N+2
        for (int c = 0; c < 12; c++) begin
            step(c < 8, 1'b1, 16'h0100 + 16'(4 * c), 32'h0, 4'h0, 1'b1);
            if (c < 8) chk($sformatf("b2b_ready%0d", c), cmd_ready, 1);
            if (c >= 2 && c < 10) begin
                chk($sformatf("b2b_valid%0d", c), rsp_valid, 1);
                chk($sformatf("b2b_rdata%0d", c), rsp_rdata, pat(14'(64 + c - 2)));
            end else chk($sformatf("b2b_idle%0d", c), rsp_valid, 0);
        end

        // Backpressure: only RSP_DEPTH accepts, head held stable
        acc_n = 0;
        for (int c = 0; c < 10; c++) begin
            step(1'b1, 1'b1, 16'h0200 + 16'(4 * acc_n), 32'h0, 4'h0, 1'b0);
            if (cmd_ready) acc_n++;
            if (rsp_valid) chk($sformatf("bp_hold%0d", c), rsp_rdata, pat(14'd128));
        end
        chk("bp_accepts", acc_n, 2);
        chk("bp_ready_low", cmd_ready, 0);
        chk("bp_valid", rsp_valid, 1);
        step(1'b1, 1'b1, 16'h0208, 32'h0, 4'h0, 1'b1);
        chk("bp_release_ready", cmd_ready, 1);
        chk("bp_drain0", rsp_rdata, pat(14'd128));
        step(1'b0, 1'b1, 16'h0, 32'h0, 4'h0, 1'b1);
        chk("bp_drain1", rsp_rdata, pat(14'd129));
        step(1'b0, 1'b1, 16'h0, 32'h0, 4'h0, 1'b1);
        chk("bp_drain2_v", rsp_valid, 1);
        chk("bp_drain2", rsp_rdata, pat(14'd130));
        step(1'b0, 1'b1, 16'h0, 32'h0, 4'h0, 1'b1);
        chk("bp_empty", rsp_valid, 0);

        // Asynchronous reset with a full FIFO
        for (int c = 0; c < 4; c++) step(1'b1, 1'b1, 16'h0300, 32'h0, 4'h0, 1'b0);
        chk("mr_full", rsp_valid, 1);
        #1 rst = 1;
        #1;
        chk("mr_rsp_valid", rsp_valid, 0);
        chk("mr_cmd_ready", cmd_ready, 0);
        chk("mr_ram_cs", ram_cs, 0);
        repeat (2) @(negedge clk);
        rst = 0;
        step(1'b0, 1'b1, 16'h0, 32'h0, 4'h0, 1'b1);
        chk("mr_after_empty", rsp_valid, 0);
        step(1'b1, 1'b1, 16'h0010, 32'h0, 4'h0, 1'b1);
        chk("mr_rd_ready", cmd_ready, 1);
        chk("mr_rd_cs", ram_cs, 1);
        step(1'b0, 1'b1, 16'h0, 32'h0, 4'h0, 1'b1);
        chk("mr_rd_n1", rsp_valid, 0);
        step(1'b0, 1'b1, 16'h0, 32'h0, 4'h0, 1'b1);
        chk("mr_rd_n2_v", rsp_valid, 1);
        chk("mr_rd_n2_d", rsp_rdata, 32'hDEADBEEF);
        step(1'b0, 1'b1, 16'h0, 32'h0, 4'h0, 1'b1);
        chk("mr_rd_done", rsp_valid, 0);

        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end

endmodule
